// File: rtl/pc_ctrl_ras.sv
// Fetch program-counter controller with exception/return path and a
// circular return-address stack. All state advances on the falling edge so
// the instruction SRAM can sample pc on the following rising edge.
module pc_ctrl_ras #(
  parameter int unsigned   AW         = 32,
  parameter logic [AW-1:0] RESET_PC   = '0,
  parameter int unsigned   STEP       = 4,
  parameter logic [31:0]   EXC_VECTOR = 32'h0000_0100,
  parameter int unsigned   RAS_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           branch,
  input  logic [AW-1:0]                  branch_pc,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           exc,
  input  logic                           eret,
  output logic [AW-1:0]                  pc,
  output logic [AW-1:0]                  epc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_err,
  output logic                           redirect
);

  localparam int unsigned   CW       = $clog2(RAS_DEPTH + 1);
  localparam int unsigned   PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [AW-1:0] STEP_AW  = AW'(STEP);
  localparam logic [AW-1:0] EXC_PC   = AW'(EXC_VECTOR);
  localparam logic [PW-1:0] LAST_IDX = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] epc_q, epc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          redir_q, redir_d;
  // wp_q is the slot the next push writes; the top of stack sits one below it.
  // Pushing past full simply laps the ring, dropping the oldest entry.
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] wp_inc, wp_dec;
  logic [AW-1:0] pc_seq;
  logic          push;
  logic [AW-1:0] ras_q [RAS_DEPTH];

  // Next-state selection by strict priority exc > eret > branch > ret > stall > sequential.
  always_comb begin
    pc_seq  = pc_q + STEP_AW;
    wp_inc  = (wp_q == LAST_IDX) ? '0 : wp_q + PW'(1);
    wp_dec  = (wp_q == '0) ? LAST_IDX : wp_q - PW'(1);
    pc_d    = pc_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    redir_d = 1'b0;
    wp_d    = wp_q;
    push    = 1'b0;
    if (exc) begin
      epc_d   = pc_q;
      pc_d    = EXC_PC;
      redir_d = 1'b1;
    end else if (eret) begin
      pc_d    = epc_q;
      redir_d = 1'b1;
    end else if (branch) begin
      pc_d    = branch_pc;
      redir_d = 1'b1;
      if (call) begin
        push  = 1'b1;
        wp_d  = wp_inc;
        cnt_d = (cnt_q == FULL_CNT) ? FULL_CNT : cnt_q + CW'(1);
      end
    end else if (ret) begin
      if (cnt_q != '0) begin
        pc_d    = ras_q[wp_dec];
        wp_d    = wp_dec;
        cnt_d   = cnt_q - CW'(1);
        redir_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (!stall) begin
      pc_d = pc_seq;
    end
  end

  // Control state register, cleared asynchronously.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      redir_q <= 1'b0;
      wp_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      redir_q <= redir_d;
      wp_q    <= wp_d;
    end
  end

  // Stack storage; contents are meaningless while ras_count is zero, so no reset.
  always_ff @(negedge clk) begin
    if (push) begin
      ras_q[wp_q] <= pc_seq;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign ras_count = cnt_q;
  assign ras_err   = err_q;
  assign redirect  = redir_q;

endmodule

// File: tb/tb_pc_ctrl_ras.sv
// Directed bench for pc_ctrl_ras: a 32-bit instance for sequencing, RAS and
// exception behaviour, and an 8-bit instance for wrap-around and reset vector.
module tb_pc_ctrl_ras;

  logic        clk;
  logic        rst_n, rst8_n;
  logic        stall, branch, call, ret, exc, eret;
  logic [31:0] branch_pc;
  logic [31:0] pc, epc;
  logic [2:0]  ras_count;
  logic        ras_err, redirect;

  logic [7:0]  pc8, epc8;
  logic [2:0]  ras_count8;
  logic        ras_err8, redirect8;

  int checks = 0;
  int errors = 0;

  pc_ctrl_ras #(.AW(32), .RESET_PC(32'h0), .STEP(4), .EXC_VECTOR(32'h100), .RAS_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .branch_pc(branch_pc),
    .call(call), .ret(ret), .exc(exc), .eret(eret),
    .pc(pc), .epc(epc), .ras_count(ras_count), .ras_err(ras_err), .redirect(redirect)
  );

  pc_ctrl_ras #(.AW(8), .RESET_PC(8'hF0), .STEP(4), .RAS_DEPTH(4)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .stall(1'b0), .branch(1'b0), .branch_pc(8'h00),
    .call(1'b0), .ret(1'b0), .exc(1'b0), .eret(1'b0),
    .pc(pc8), .epc(epc8), .ras_count(ras_count8), .ras_err(ras_err8), .redirect(redirect8)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] bpc,
                       input logic cl, input logic rt, input logic ex, input logic er);
    stall = st; branch = br; branch_pc = bpc; call = cl; ret = rt; exc = ex; eret = er;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    rst8_n = 1'b0;
    idle();

    // release mid-cycle, between falling edges
    @(posedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_cnt", {29'b0, ras_count}, 32'd0);
    check("rst_err", {31'b0, ras_err}, 32'd0);
    check("rst_redir", {31'b0, redirect}, 32'd0);

    tick(); check("seq1", pc, 32'h4);
    tick(); check("seq2", pc, 32'h8);
    tick(); check("seq3", pc, 32'hC); check("seq3_redir", {31'b0, redirect}, 32'd0);
    tick(); check("seq4", pc, 32'h10);

    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); check("stall1", pc, 32'h10);
    tick(); check("stall2", pc, 32'h10); check("stall_redir", {31'b0, redirect}, 32'd0);
    drive(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); check("stall_br_pc", pc, 32'h80); check("stall_br_redir", {31'b0, redirect}, 32'd1);

    // call / return
    drive(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); check("br20", pc, 32'h20); check("br20_cnt", {29'b0, ras_count}, 32'd0);
    drive(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); check("call_pc", pc, 32'h200); check("call_cnt", {29'b0, ras_count}, 32'd1);
    idle();
    tick(); check("after_call", pc, 32'h204); check("after_call_redir", {31'b0, redirect}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); check("ret_pc", pc, 32'h24); check("ret_cnt", {29'b0, ras_count}, 32'd0);
    check("ret_redir", {31'b0, redirect}, 32'd1);
    tick(); check("eret_empty_pc", pc, 32'h24); check("empty_err", {31'b0, ras_err}, 32'd1);
    check("empty_redir", {31'b0, redirect}, 32'd0); check("empty_cnt", {29'b0, ras_count}, 32'd0);
    idle();
    tick(); check("err_sticky", {31'b0, ras_err}, 32'd1); check("after_err_pc", pc, 32'h28);

    // asynchronous reset pulse mid-cycle
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("apulse_pc", pc, 32'h0);
    check("apulse_err", {31'b0, ras_err}, 32'd0);
    check("apulse_redir", {31'b0, redirect}, 32'd0);
    #1;
    rst_n = 1'b1;

    // overflow: five calls from 0x0 .. 0x400
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 32'(k + 1) * 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("ovf_call_pc", pc, 32'(k + 1) * 32'h100);
      check("ovf_call_cnt", {29'b0, ras_count}, (k < 4) ? 32'(k + 1) : 32'd4);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      tick();
      check("ovf_ret_pc", pc, 32'h404 - 32'(j) * 32'h100);
      check("ovf_ret_cnt", {29'b0, ras_count}, 32'(3 - j));
    end
    check("ovf_noerr", {31'b0, ras_err}, 32'd0);
    tick();
    check("ovf_ret5_pc", pc, 32'h104);
    check("ovf_ret5_err", {31'b0, ras_err}, 32'd1);
    check("ovf_ret5_redir", {31'b0, redirect}, 32'd0);

    // exception priority
    drive(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); check("pre_exc_pc", pc, 32'h40); check("pre_exc_cnt", {29'b0, ras_count}, 32'd1);
    drive(1'b0, 1'b1, 32'h999, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("exc_pc", pc, 32'h100); check("exc_epc", epc, 32'h40);
    check("exc_cnt", {29'b0, ras_count}, 32'd1); check("exc_redir", {31'b0, redirect}, 32'd1);
    idle();
    tick(); check("handler_seq", pc, 32'h104);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); check("eret_pc", pc, 32'h40); check("eret_epc", epc, 32'h40);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); check("ret_after_exc", pc, 32'h108); check("ret_after_exc_cnt", {29'b0, ras_count}, 32'd0);
    drive(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); check("eret_blk_pc", pc, 32'h40); check("eret_blk_cnt", {29'b0, ras_count}, 32'd0);
    idle();

    // 8-bit instance: reset vector and wrap
    @(posedge clk);
    rst8_n = 1'b1;
    #1;
    check("w8_rst", {24'b0, pc8}, 32'hF0);
    tick(); check("w8_s1", {24'b0, pc8}, 32'hF4);
    tick(); check("w8_s2", {24'b0, pc8}, 32'hF8);
    tick(); check("w8_s3", {24'b0, pc8}, 32'hFC);
    tick(); check("w8_wrap", {24'b0, pc8}, 32'h00); check("w8_wrap_redir", {31'b0, redirect8}, 32'd0);
    tick(); check("w8_after", {24'b0, pc8}, 32'h04);
    @(posedge clk);
    #1;
    rst8_n = 1'b0;
    #1;
    check("w8_apulse_pc", {24'b0, pc8}, 32'hF0);
    check("w8_apulse_cnt", {29'b0, ras_count8}, 32'd0);
    check("w8_apulse_err", {31'b0, ras_err8}, 32'd0);
    check("w8_apulse_epc", {24'b0, epc8}, 32'h0);
    #1;
    rst8_n = 1'b1;
    tick(); check("w8_post_rst", {24'b0, pc8}, 32'hF4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
